stream_to_bram: RTL and testbench

Captures 32-bit AXI-stream beats into a block RAM through its write port, starting either immediately or on an orbit boundary and stopping after a programmed number of words. It is the capture-side counterpart of the BRAM playback source: link or fast-command data is snapshotted into BRAM so software can read it back over the BRAM's other port.

---
 rtl/stream_to_bram_pkg.sv | 17 +
 rtl/stream_to_bram_if.sv | 22 ++
 rtl/stream_to_bram_orbit_edge_detect.sv | 24 ++
 rtl/stream_to_bram.sv | 189 ++++++++++++++++++
 tb/tb_stream_to_bram.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_to_bram_pkg.sv
// stream_to_bram_pkg: shared types and constants for the stream-to-BRAM capture block.

package stream_to_bram_pkg;

    // Capture controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } s2b_state_t;

    // Values of capture_mode.
    localparam logic MODE_IMMEDIATE = 1'b0;
    localparam logic MODE_ORBIT     = 1'b1;

endpackage

// File: rtl/stream_to_bram_if.sv
// stream_to_bram_if: 32-bit AXI-stream beat bundle (data, valid, ready).
// master drives data/valid, slave (the capture block) drives ready.

interface stream_to_bram_if;

    logic [31:0] TDATA;
    logic        TVALID;
    logic        TREADY;

    modport master (
        output TDATA,
        output TVALID,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TVALID,
        output TREADY
    );

endinterface

// File: rtl/stream_to_bram_orbit_edge_detect.sv
// stream_to_bram_orbit_edge_detect: registers the orbit sync level and
// produces a one-cycle pulse on its rising edge.

module stream_to_bram_orbit_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sync_i,
    output logic rise_o
);

    logic sync_q;

    // Delayed copy of the sync level, updated every cycle regardless of stream flow.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_i;
        end
    end

    assign rise_o = sync_i & ~sync_q;

endmodule

// File: rtl/stream_to_bram.sv
// stream_to_bram: captures 32-bit stream beats into a BRAM write port, starting
// immediately or on an orbit-sync rising edge, and stops after a programmed word count.
// Optional feature macro STREAM_TO_BRAM_ORBIT_COUNT_EN adds capture_orbits[15:0], a
// saturating count of orbit edges seen while capturing.

module stream_to_bram
    import stream_to_bram_pkg::*;
#(
    parameter  int unsigned MEM_DEPTH = 2048,
    localparam int unsigned AW        = $clog2(MEM_DEPTH)
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                arm,
    input  logic                abort,
    input  logic                capture_mode,
    input  logic [15:0]         capture_len,
    input  logic                fc_orbitSync,
    stream_to_bram_if.slave     data_stream,
    output logic                bram_CLK,
    output logic                bram_RST,
    output logic                bram_EN,
    output logic [3:0]          bram_WE,
    output logic [31:0]         bram_ADDR,
    output logic [31:0]         bram_DIN,
    output logic                busy,
    output logic                done,
    output logic [AW:0]         words_captured
`ifdef STREAM_TO_BRAM_ORBIT_COUNT_EN
    ,
    output logic [15:0]         capture_orbits
`endif
);

    typedef logic [AW:0]   cnt_t;
    typedef logic [AW-1:0] ptr_t;

    s2b_state_t state_q;
    logic       mode_q;
    cnt_t       len_q;
    ptr_t       word_ptr_q;
    cnt_t       words_q;
    logic       tready_q;
    logic       busy_q;
    logic       done_q;

    logic       orbit_rise;
    logic       trigger;
    logic       accept;
    logic       write_en;
    logic       last_write;
    logic       arm_take;
    cnt_t       len_eff;
    cnt_t       words_inc;

    stream_to_bram_orbit_edge_detect u_orbit_edge_detect (
        .clk_i  (clk),
        .rst_ni (aresetn),
        .sync_i (fc_orbitSync),
        .rise_o (orbit_rise)
    );

    // Effective capture length: zero or anything beyond the memory means full depth.
    always_comb begin
        if (capture_len == 16'd0 || 32'(capture_len) > MEM_DEPTH) begin
            len_eff = cnt_t'(MEM_DEPTH);
        end else begin
            len_eff = cnt_t'(capture_len);
        end
    end

    // Handshake decode: which beat is written this cycle and what it completes.
    always_comb begin
        trigger  = (mode_q == MODE_ORBIT) ? orbit_rise : 1'b1;
        accept   = data_stream.TVALID & tready_q;
        write_en = 1'b0;
        // abort wins over any write in the same cycle
        if (accept && !abort) begin
            if (state_q == CAPTURE || (state_q == ARMED && trigger)) begin
                write_en = 1'b1;
            end
        end
        words_inc  = words_q + cnt_t'(1);
        last_write = write_en && (words_inc == len_q);
        arm_take   = arm && !abort && (state_q == IDLE || state_q == DONE);
    end

    // Control FSM: state, latched configuration and registered status flags.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            mode_q  <= MODE_IMMEDIATE;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        state_q <= ARMED;
                        mode_q  <= capture_mode;
                        len_q   <= len_eff;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ARMED: begin
                    if (trigger) begin
                        if (last_write) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (last_write) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: stream ready, write pointer and captured-word counter.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            tready_q   <= 1'b0;
            word_ptr_q <= '0;
            words_q    <= '0;
        end else begin
            tready_q <= 1'b1;
            if (arm_take) begin
                word_ptr_q <= '0;
                words_q    <= '0;
            end else if (write_en) begin
                words_q <= words_inc;
                // Hold on the final word so a full-depth capture never wraps the pointer
                if (!last_write) begin
                    word_ptr_q <= word_ptr_q + ptr_t'(1);
                end
            end
        end
    end

`ifdef STREAM_TO_BRAM_ORBIT_COUNT_EN
    logic [15:0] orbits_q;

    // Saturating count of orbit edges while capturing; the trigger edge occurs in ARMED.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            orbits_q <= 16'd0;
        end else if (arm_take) begin
            orbits_q <= 16'd0;
        end else if (state_q == CAPTURE && orbit_rise && orbits_q != 16'hFFFF) begin
            orbits_q <= orbits_q + 16'd1;
        end
    end

    assign capture_orbits = orbits_q;
`endif

    assign data_stream.TREADY = tready_q;

    assign bram_CLK  = clk;
    assign bram_RST  = ~aresetn;
    assign bram_EN   = write_en;
    assign bram_WE   = {4{write_en}};
    assign bram_ADDR = {{(30 - AW){1'b0}}, word_ptr_q, 2'b00};
    assign bram_DIN  = data_stream.TDATA;

    assign busy           = busy_q;
    assign done           = done_q;
    assign words_captured = words_q;

endmodule

// File: tb/tb_stream_to_bram.sv
// tb_stream_to_bram: directed stimulus with a per-cycle reference model and
// hand-computed checks of captured memory contents and counters.

module tb_stream_to_bram;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        arm;
    logic        abort;
    logic        capture_mode;
    logic [15:0] capture_len;
    logic        fc_orbitSync;
    logic        bram_CLK;
    logic        bram_RST;
    logic        bram_EN;
    logic [3:0]  bram_WE;
    logic [31:0] bram_ADDR;
    logic [31:0] bram_DIN;
    logic        busy;
    logic        done;
    logic [4:0]  words_captured;
`ifdef STREAM_TO_BRAM_ORBIT_COUNT_EN
    logic [15:0] capture_orbits;
`endif

    stream_to_bram_if s_if ();

    stream_to_bram #(
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .arm            (arm),
        .abort          (abort),
        .capture_mode   (capture_mode),
        .capture_len    (capture_len),
        .fc_orbitSync   (fc_orbitSync),
        .data_stream    (s_if),
        .bram_CLK       (bram_CLK),
        .bram_RST       (bram_RST),
        .bram_EN        (bram_EN),
        .bram_WE        (bram_WE),
        .bram_ADDR      (bram_ADDR),
        .bram_DIN       (bram_DIN),
        .busy           (busy),
        .done           (done),
        .words_captured (words_captured)
`ifdef STREAM_TO_BRAM_ORBIT_COUNT_EN
        ,
        .capture_orbits (capture_orbits)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 waiting for trigger, 2 collecting, 3 full.
    int          m_phase    = 0;
    logic        m_mode     = 1'b0;
    int          m_target   = 0;
    logic [31:0] m_words[$];
    logic        m_ready    = 1'b0;
    logic        m_prev     = 1'b0;
    int          m_orbits   = 0;
    logic        m_trig;
    logic        m_wr;

    // Memory as the BRAM would hold it, built from observed DUT writes.
    logic [31:0] bram_mem [DEPTH];
    int          n_writes   = 0;
    logic [31:0] last_addr  = 32'd0;

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin
        m_trig = (m_mode == 1'b0) || (fc_orbitSync && !m_prev);
        m_wr   = m_ready && s_if.TVALID && !abort &&
                 (m_phase == 2 || (m_phase == 1 && m_trig));

        check("en", bram_EN, m_wr);
        check("we", bram_WE, m_wr ? 32'hF : 32'h0);
        if (m_wr) begin
            check("addr", bram_ADDR, 32'(m_words.size() * 4));
            check("din", bram_DIN, s_if.TDATA);
        end
        check("busy", busy, (m_phase == 1 || m_phase == 2));
        check("done", done, (m_phase == 3));
        check("words", words_captured, 32'(m_words.size()));
        check("tready", s_if.TREADY, m_ready);
`ifdef STREAM_TO_BRAM_ORBIT_COUNT_EN
        check("orbits", capture_orbits, 32'(m_orbits));
`endif

        if (bram_EN) begin
            bram_mem[bram_ADDR[5:2]] = bram_DIN;
            n_writes++;
            last_addr = bram_ADDR;
        end

        if (!aresetn) begin
            m_phase  = 0;
            m_mode   = 1'b0;
            m_words.delete();
            m_ready  = 1'b0;
            m_orbits = 0;
            m_prev   = 1'b0;
        end else begin
            if (m_phase == 2 && fc_orbitSync && !m_prev && m_orbits < 65535) m_orbits++;
            if (m_wr) m_words.push_back(s_if.TDATA);
            if (abort) begin
                m_phase = 0;
            end else if (arm && (m_phase == 0 || m_phase == 3)) begin
                m_phase  = 1;
                m_mode   = capture_mode;
                m_target = (capture_len == 16'd0 || int'(capture_len) > DEPTH) ?
                           DEPTH : int'(capture_len);
                m_words.delete();
                m_orbits = 0;
            end else if (m_phase == 1 && m_trig) begin
                m_phase = (m_words.size() == m_target) ? 3 : 2;
            end else if (m_phase == 2 && m_words.size() == m_target) begin
                m_phase = 3;
            end
            m_ready = 1'b1;
            m_prev  = fc_orbitSync;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int w0;

    initial begin
        aresetn      = 1'b0;
        arm          = 1'b0;
        abort        = 1'b0;
        capture_mode = 1'b0;
        capture_len  = 16'd0;
        fc_orbitSync = 1'b0;
        s_if.TDATA   = 32'd0;
        s_if.TVALID  = 1'b0;

        // Reset values
        cyc();
        cyc();
        @(negedge clk);
        check("rst_tready", s_if.TREADY, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words", words_captured, 0);
        check("rst_en", bram_EN, 0);
        check("rst_we", bram_WE, 0);
        check("rst_addr", bram_ADDR, 0);
        check("rst_bram_rst", bram_RST, 1);
        cyc();
        aresetn = 1'b1;
        cyc();
        @(negedge clk);
        check("tready_up", s_if.TREADY, 1);

        // Mode 0, length 4, continuous beats A0..A7
        w0 = n_writes;
        cyc();
        arm = 1'b1; capture_mode = 1'b0; capture_len = 16'd4;
        for (int k = 0; k < 8; k++) begin
            cyc();
            arm = 1'b0; s_if.TVALID = 1'b1; s_if.TDATA = 32'hA0 + 32'(k);
        end
        cyc();
        s_if.TVALID = 1'b0;
        cyc();
        @(negedge clk);
        check("t1_writes", 32'(n_writes - w0), 4);
        check("t1_mem0", bram_mem[0], 32'hA0);
        check("t1_mem1", bram_mem[1], 32'hA1);
        check("t1_mem2", bram_mem[2], 32'hA2);
        check("t1_mem3", bram_mem[3], 32'hA3);
        check("t1_last_addr", last_addr, 32'hC);
        check("t1_done", done, 1);
        check("t1_words", words_captured, 4);
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;

        // Mode 1, length 3; orbit edge with arm is ignored, edge at k=10 triggers
        w0 = n_writes;
        for (int k = 0; k < 16; k++) begin
            cyc();
            arm          = (k == 0);
            capture_mode = 1'b1;
            capture_len  = 16'd3;
            fc_orbitSync = (k == 0) || (k >= 10 && k <= 13);
            s_if.TVALID  = 1'b1;
            s_if.TDATA   = 32'(k);
        end
        cyc();
        s_if.TVALID = 1'b0; fc_orbitSync = 1'b0;
        cyc();
        @(negedge clk);
        check("t2_writes", 32'(n_writes - w0), 3);
        check("t2_mem0", bram_mem[0], 32'd10);
        check("t2_mem1", bram_mem[1], 32'd11);
        check("t2_mem2", bram_mem[2], 32'd12);
        check("t2_mem3", bram_mem[3], 32'hA3);
        check("t2_done", done, 1);
        check("t2_words", words_captured, 3);

        // Re-arm from DONE with length 0 -> full 16-word depth
        w0 = n_writes;
        for (int k = 0; k < 20; k++) begin
            cyc();
            arm          = (k == 0);
            capture_mode = 1'b0;
            capture_len  = 16'd0;
            s_if.TVALID  = 1'b1;
            s_if.TDATA   = 32'd100 + 32'(k);
        end
        cyc();
        s_if.TVALID = 1'b0;
        cyc();
        @(negedge clk);
        check("t3_writes", 32'(n_writes - w0), 16);
        check("t3_last_addr", last_addr, 32'h3C);
        check("t3_words", words_captured, 16);
        check("t3_done", done, 1);
        check("t3_mem0", bram_mem[0], 32'd101);
        check("t3_mem15", bram_mem[15], 32'd116);
        for (int i = 0; i < m_words.size(); i++) begin
            check("t3_model_mem", bram_mem[i], m_words[i]);
        end

        // Gappy valid, length 2
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        w0 = n_writes;
        for (int k = 0; k < 6; k++) begin
            cyc();
            arm         = (k == 0);
            capture_len = 16'd2;
            s_if.TVALID = (k % 2 == 1);
            s_if.TDATA  = 32'h11 * 32'(k);
        end
        cyc();
        s_if.TVALID = 1'b0;
        cyc();
        @(negedge clk);
        check("t4_writes", 32'(n_writes - w0), 2);
        check("t4_mem0", bram_mem[0], 32'h11);
        check("t4_mem1", bram_mem[1], 32'h33);
        check("t4_done", done, 1);

        // Abort together with a valid beat mid-capture
        w0 = n_writes;
        for (int k = 0; k < 5; k++) begin
            cyc();
            arm         = (k == 0);
            capture_len = 16'd8;
            s_if.TVALID = 1'b1;
            s_if.TDATA  = 32'h500 + 32'(k);
            abort       = (k == 4);
        end
        cyc();
        abort = 1'b0; s_if.TVALID = 1'b0;
        @(negedge clk);
        check("t5_writes", 32'(n_writes - w0), 3);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_words", words_captured, 3);
        cyc();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        @(negedge clk);
        check("t5_rearm_words", words_captured, 0);
        check("t5_rearm_busy", busy, 1);

        // Reset pulse mid-capture, with an orbit edge seen while capturing
        for (int k = 0; k < 3; k++) begin
            cyc();
            s_if.TVALID  = (k < 2);
            s_if.TDATA   = 32'h600 + 32'(k);
            fc_orbitSync = (k == 1);
        end
        @(negedge clk);
        check("t6_words", words_captured, 2);
        check("t6_busy", busy, 1);
`ifdef STREAM_TO_BRAM_ORBIT_COUNT_EN
        check("t6_orbits", capture_orbits, 1);
`endif
        cyc();
        aresetn = 1'b0; s_if.TVALID = 1'b0; fc_orbitSync = 1'b0;
        cyc();
        aresetn = 1'b1;
        @(negedge clk);
        check("t6_rst_tready", s_if.TREADY, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_words", words_captured, 0);
`ifdef STREAM_TO_BRAM_ORBIT_COUNT_EN
        check("t6_rst_orbits", capture_orbits, 0);
`endif
        cyc();
        @(negedge clk);
        check("t6_tready_up", s_if.TREADY, 1);

        cyc();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
